cond_front: RTL and testbench
=============================

# cond_front

Condition front-end for the microprogram sequencer. It takes up to `cw` raw, asynchronous status inputs and synchronizes them, with optional filtering. Each channel then goes through per-channel event capture: level, rising-sticky, falling-sticky or any-edge-sticky. The resulting registered `cond` vector drives the sequencer's `cond` port. Sticky channels are acknowledged by a clear mask that the microprogram drives from a field of its `out_sig` control word.

## Interface
Parameters:
- `ncs`, 3, select width of the sequencer condition mux; `cw = (1<<ncs)-1` channels (7).
- `flt`, 3, filter depth in consecutive cycles (≥2; used only with the filter macro).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `raw_in`  in  cw  asynchronous status inputs.
- `mode`  in  2*cw  per-channel mode; bits [2i+1:2i] belong to channel i. Quasi-static.
- `clr`  in  cw  per-channel sticky/overrun clear, synchronous to `clk`, driven from a sequencer `out_sig` field.
- `cond`  out  cw  conditions to the sequencer.
- `ovf`  out  cw  per-channel overrun flags.

## Operation
Each channel is independent and identical.
- **Synchronizer:** two flops, `s1 <= raw_in[i]`, `s2 <= s1`.
- **Level register `lvl`:** without the filter macro, `lvl <= s2` every cycle.
- **Event:** `evt` is true on the cycle `lvl` is about to change.
  - `rise` = `evt` and the new value is 1.
  - `fall` = `evt` and the new value is 0.
- **Modes:**
  - 00 LEVEL: `cond = lvl`; sticky and ovf are held at 0.
  - 01 RISE: sticky is set by `rise`.
  - 10 FALL: sticky is set by `fall`.
  - 11 ANY: sticky is set by either `rise` or `fall`.
- **Output mux:** `cond = (mode==LEVEL) ? lvl : sticky`.
- **Sticky update, in priority order:**
  1. Mode changed from last cycle: sticky is cleared and ovf is cleared.
  2. A qualifying event occurs: sticky becomes 1. If sticky was already 1 and `clr` is 0, ovf becomes 1. If `clr` is 1 in the same cycle, the event wins: sticky stays 1 and ovf is not set.
  3. `clr` = 1: sticky becomes 0 and ovf becomes 0.
  4. Otherwise both hold.
- **Reset start-up:** `lvl` resets to 0. A raw input already high at reset release therefore yields exactly one rising event once it propagates. This is intended: software sees initially-active sources.
- `ovf` is sticky until `clr` or a mode change.

## Timing
- Reset: `s1`, `s2`, `lvl`, filter counter, sticky, ovf, and the stored previous mode all reset to 0. `cond` and `ovf` therefore reset to 0.
- Every output is a register or a mux of registers selected by `mode`. There is no combinational path from `raw_in` or `clr` to any output.
- Latency without the filter: a `raw_in` change setting up before edge 0 updates `s1` at edge 0, `s2` at edge 1, and `lvl`/sticky at edge 2. `cond` is valid after edge 2, which is 3 edges counting the sampling edge.
- Latency with the filter: 2 + `flt` edges (default 5).
- `clr` takes effect on the next edge: `cond` drops one cycle after `clr` is sampled.
- Mode change: sticky and ovf are 0 one cycle after the new mode is sampled.
- Reset asserted mid-operation clears everything immediately, with no pending events kept.

## Configuration
- `COND_FRONT_FILTER_EN` defined:
  - Each channel gets a counter of width `$clog2(flt)`.
  - When `s2 != lvl`, the counter increments. When `s2 == lvl`, the counter resets to 0.
  - When the counter equals `flt-1` and `s2 != lvl`: `lvl <= s2`, the counter goes to 0, and `evt` fires.
  - Pulses shorter than `flt` cycles at `s2` are discarded.
- `COND_FRONT_FILTER_EN` undefined:
  - No counter.
  - `lvl <= s2` each cycle; `evt = (s2 != lvl)`.

## Structure
- Package `cond_front_pkg`:
  - mode constants `MODE_LEVEL = 2'b00`, `MODE_RISE = 2'b01`, `MODE_FALL = 2'b10`, `MODE_ANY = 2'b11`;
  - a 2-bit `cond_mode_t` typedef.
- Sub-module `cond_chan`: one channel (sync, optional filter, edge detect, sticky/ovf). It is instantiated `cw` times by a generate loop in `cond_front`.
- The top level only slices `mode` and concatenates the outputs.

## Test plan
- **Reset start-up:** `raw_in=7'h01` held through reset, `mode`=RISE on all channels, release `reset_n` → `cond[0]` rises 3 edges after release (no filter), other bits stay 0, `ovf=0`.
- **Level mode:** toggle `raw_in[3]` 0→1→0 with 10-cycle spacing, `mode[7:6]=00` → `cond[3]` follows with 3-cycle delay (5 with filter); `ovf[3]` stays 0.
- **Sticky, clear, overrun, clr/event collision:** channel 2 in RISE; send two rising pulses without `clr` → `cond[2]=1` and `ovf[2]=1`. Assert `clr[2]` for 1 cycle → both 0 the next cycle. Assert `clr[2]` on the same edge an event lands → `cond[2]` stays 1, `ovf[2]` stays 0.
- **Filter (macro defined, `flt=3`):** 2-cycle high glitch on `raw_in[5]` → no change on `cond[5]`. 3-cycle high → `cond[5]` rises 5 edges after the first sampled high.
- **Mode change and async reset:** channel 6 in ANY with sticky and ovf set; switch to FALL → both 0 one cycle later. Then pulse `reset_n` low mid-cycle → `cond`, `ovf` = 0 immediately.

Source files
------------

// File: rtl/cond_front_pkg.sv
// Shared mode encodings for the condition front-end.
package cond_front_pkg;

  typedef logic [1:0] cond_mode_t;

  localparam cond_mode_t MODE_LEVEL = 2'b00;
  localparam cond_mode_t MODE_RISE  = 2'b01;
  localparam cond_mode_t MODE_FALL  = 2'b10;
  localparam cond_mode_t MODE_ANY   = 2'b11;

endpackage

// File: rtl/cond_chan.sv
// One condition channel: 2-flop sync, optional glitch filter, edge detect, sticky/overrun.
// Optional filter enabled by defining COND_FRONT_FILTER_EN.
module cond_chan
  import cond_front_pkg::*;
#(
  parameter int flt = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw,
  input  cond_mode_t mode,
  input  logic       clr,
  output logic       cond,
  output logic       ovf
);

  logic       s1_p0;
  logic       s2_p1;
  logic       lvl_p2;
  logic       sticky_p2;
  logic       ovf_p2;
  cond_mode_t mode_q;
  logic       evt;
  logic       rise;
  logic       fall;
  logic       qual;

  // stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_p0 <= 1'b0;
      s2_p1 <= 1'b0;
    end else begin
      s1_p0 <= raw;
      s2_p1 <= s1_p0;
    end
  end

`ifdef COND_FRONT_FILTER_EN
  localparam int CNT_W = (flt > 1) ? $clog2(flt) : 1;
  logic [CNT_W-1:0] cnt_p2;

  assign evt = (s2_p1 != lvl_p2) && (cnt_p2 == CNT_W'(flt - 1));

  // stage p2: level only moves after flt consecutive differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p2 <= '0;
      lvl_p2 <= 1'b0;
    end else if (evt) begin
      cnt_p2 <= '0;
      lvl_p2 <= s2_p1;
    end else if (s2_p1 != lvl_p2) begin
      cnt_p2 <= cnt_p2 + 1'b1;
    end else begin
      cnt_p2 <= '0;
    end
  end
`else
  logic unused_flt;
  assign unused_flt = (flt > 1);
  assign evt        = (s2_p1 != lvl_p2);

  // stage p2: level register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lvl_p2 <= 1'b0;
    else          lvl_p2 <= s2_p1;
  end
`endif

  assign rise = evt & s2_p1;
  assign fall = evt & ~s2_p1;

  always_comb begin
    qual = 1'b0;
    case (mode)
      MODE_RISE: qual = rise;
      MODE_FALL: qual = fall;
      MODE_ANY:  qual = evt;
      default:   qual = 1'b0;
    endcase
  end

  // stage p2: sticky capture; a landing event beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= MODE_LEVEL;
      sticky_p2 <= 1'b0;
      ovf_p2    <= 1'b0;
    end else begin
      mode_q <= mode;
      if (mode != mode_q) begin
        sticky_p2 <= 1'b0;
        ovf_p2    <= 1'b0;
      end else if (qual) begin
        sticky_p2 <= 1'b1;
        if (sticky_p2 && !clr) ovf_p2 <= 1'b1;
      end else if (clr) begin
        sticky_p2 <= 1'b0;
        ovf_p2    <= 1'b0;
      end
    end
  end

  assign cond = (mode == MODE_LEVEL) ? lvl_p2 : sticky_p2;
  assign ovf  = ovf_p2;

endmodule

// File: rtl/cond_front.sv
// Condition front-end: cw independent cond_chan instances feeding the sequencer cond port.
// Optional per-channel glitch filter enabled by defining COND_FRONT_FILTER_EN.
module cond_front
  import cond_front_pkg::*;
#(
  parameter int ncs = 3,
  parameter int flt = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [(1<<ncs)-2:0]        raw_in,
  input  logic [2*((1<<ncs)-1)-1:0]  mode,
  input  logic [(1<<ncs)-2:0]        clr,
  output logic [(1<<ncs)-2:0]        cond,
  output logic [(1<<ncs)-2:0]        ovf
);

  localparam int cw = (1 << ncs) - 1;

  for (genvar i = 0; i < cw; i++) begin : g_chan
    cond_chan #(
      .flt (flt)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw_in[i]),
      .mode    (cond_mode_t'(mode[2*i +: 2])),
      .clr     (clr[i]),
      .cond    (cond[i]),
      .ovf     (ovf[i])
    );
  end

endmodule

// File: tb/tb_cond_front.sv
// Directed bench for cond_front: reset start-up, level, sticky/overrun/clear, filter, mode change, async reset.
module tb_cond_front;

`ifdef COND_FRONT_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        reset_n;
  logic [6:0]  raw_in;
  logic [13:0] mode;
  logic [6:0]  clr;
  logic [6:0]  cond;
  logic [6:0]  ovf;

  int n_vec;
  int n_err;

  cond_front #(.ncs(3), .flt(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_in  (raw_in),
    .mode    (mode),
    .clr     (clr),
    .cond    (cond),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    raw_in  = 7'h01;
    mode    = 14'h1555;
    clr     = 7'h00;

    // reset start-up: raw_in[0] already high
    step(3);
    check("rst_cond", cond, 7'h00);
    check("rst_ovf", ovf, 7'h00);
    reset_n = 1'b1;
    step(LAT - 1);
    check("startup_early", cond, 7'h00);
    step(1);
    check("startup_cond", cond, 7'h01);
    check("startup_ovf", ovf, 7'h00);

    // level mode on channel 3
    mode[7:6] = 2'b00;
    step(4);
    raw_in[3] = 1'b1;
    step(LAT - 1);
    check("lvl_rise_early", 7'(cond[3]), 7'h00);
    step(1);
    check("lvl_rise", 7'(cond[3]), 7'h01);
    step(10 - LAT);
    raw_in[3] = 1'b0;
    step(LAT - 1);
    check("lvl_fall_early", 7'(cond[3]), 7'h01);
    step(1);
    check("lvl_fall", 7'(cond[3]), 7'h00);
    check("lvl_ovf", 7'(ovf[3]), 7'h00);

    // sticky, overrun, clear on channel 2 (RISE)
    raw_in[2] = 1'b1; step(4); raw_in[2] = 1'b0; step(6);
    check("stk_first_cond", 7'(cond[2]), 7'h01);
    check("stk_first_ovf", 7'(ovf[2]), 7'h00);
    raw_in[2] = 1'b1; step(4); raw_in[2] = 1'b0; step(6);
    check("stk_ovr_cond", 7'(cond[2]), 7'h01);
    check("stk_ovr_ovf", 7'(ovf[2]), 7'h01);
    clr[2] = 1'b1;
    step(1);
    clr[2] = 1'b0;
    check("clr_cond", 7'(cond[2]), 7'h00);
    check("clr_ovf", 7'(ovf[2]), 7'h00);

    // clear colliding with an event while already sticky: no overrun
    raw_in[2] = 1'b1; step(4); raw_in[2] = 1'b0; step(6);
    check("pre_coll_cond", 7'(cond[2]), 7'h01);
    raw_in[2] = 1'b1;
    step(LAT - 1);
    clr[2] = 1'b1;
    step(1);
    clr[2] = 1'b0;
    check("coll_cond", 7'(cond[2]), 7'h01);
    check("coll_ovf", 7'(ovf[2]), 7'h00);
    raw_in[2] = 1'b0;
    step(6);
    check("coll_after_fall", 7'(cond[2]), 7'h01);

`ifdef COND_FRONT_FILTER_EN
    // filter: 2-cycle glitch dropped, 3-cycle pulse passes
    raw_in[5] = 1'b1; step(2); raw_in[5] = 1'b0; step(8);
    check("flt_glitch", 7'(cond[5]), 7'h00);
    raw_in[5] = 1'b1; step(3); raw_in[5] = 1'b0;
    step(1);
    check("flt_pulse_early", 7'(cond[5]), 7'h00);
    step(1);
    check("flt_pulse", 7'(cond[5]), 7'h01);
    step(8);
`endif

    // channel 6 in ANY: two pulses give four events
    mode[13:12] = 2'b11;
    step(2);
    raw_in[6] = 1'b1; step(6); raw_in[6] = 1'b0; step(6);
    raw_in[6] = 1'b1; step(6); raw_in[6] = 1'b0; step(8);
    check("any_cond", 7'(cond[6]), 7'h01);
    check("any_ovf", 7'(ovf[6]), 7'h01);
    mode[13:12] = 2'b10;
    step(1);
    check("mchg_cond", 7'(cond[6]), 7'h00);
    check("mchg_ovf", 7'(ovf[6]), 7'h00);
    raw_in[6] = 1'b1; step(6); raw_in[6] = 1'b0; step(8);
    check("fall_cond", 7'(cond[6]), 7'h01);
    check("fall_ovf", 7'(ovf[6]), 7'h00);

    // asynchronous reset mid-cycle
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_cond", cond, 7'h00);
    check("async_rst_ovf", ovf, 7'h00);
    step(2);
    reset_n = 1'b1;
    step(1);
    check("post_rst_cond", cond, 7'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
